// File: rtl/uart_pixel_unpacker.sv
// Byte-stream to 12-bit pixel unpacker for the matrix frame buffer: 3 bytes become 2 pixels.
// Define UART_PIXEL_UNPACKER_SERPENTINE_EN to reverse the column order of odd rows on wr_addr.
module uart_pixel_unpacker #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned FRAME_PIXELS   = 512,
  parameter int unsigned COLS_LOG2      = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic              resync,
  output logic [1:0]        byte_phase
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(FRAME_PIXELS - 1);

  if ((FRAME_PIXELS == 0) || (FRAME_PIXELS % 2 != 0)) begin : g_bad_frame_parity
    $error("FRAME_PIXELS must be even and non-zero");
  end
  if (64'(FRAME_PIXELS) > (64'd1 << ADDR_W)) begin : g_bad_frame_size
    $error("FRAME_PIXELS does not fit in ADDR_W bits");
  end
  if ((COLS_LOG2 == 0) || (COLS_LOG2 >= ADDR_W)) begin : g_bad_cols
    $error("COLS_LOG2 must lie in 1..ADDR_W-1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    StP0 = 2'd0,
    StP1 = 2'd1,
    StP2 = 2'd2
  } phase_e;

  phase_e            phase_q;
  logic              rx_done_q;
  logic              started_q;
  logic [7:0]        a_q;
  logic [7:0]        b_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] phys_addr;
  logic [TmoW-1:0]   tmo_q;
  logic              accept;
  logic              idle;
  logic              expire;
  logic              emit;
  logic [11:0]       pix;

  // started_q masks the first cycle after reset so a level already high is not an edge.
  assign accept     = rx_done & ~rx_done_q & started_q;
  assign idle       = (phase_q == StP0) && (addr_q == '0);
  assign expire     = !idle && (tmo_q == TmoLast);
  assign byte_phase = phase_q;

  // A timeout in the same cycle as a byte turns that byte into the first of a fresh pixel.
  always_comb begin
    emit = 1'b0;
    pix  = '0;
    if (accept && !expire) begin
      unique case (phase_q)
        StP1: begin
          emit = 1'b1;
          pix  = {a_q, rx_data[7:4]};
        end
        StP2: begin
          emit = 1'b1;
          pix  = {b_q[3:0], rx_data};
        end
        default: ;
      endcase
    end
  end

`ifdef UART_PIXEL_UNPACKER_SERPENTINE_EN
  always_comb begin
    phys_addr = addr_q;
    if (addr_q[COLS_LOG2]) begin
      phys_addr[COLS_LOG2-1:0] = ~addr_q[COLS_LOG2-1:0];
    end
  end
`else
  assign phys_addr = addr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= StP0;
      rx_done_q  <= 1'b0;
      started_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      addr_q     <= '0;
      tmo_q      <= '0;
      wr         <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      resync     <= 1'b0;
    end else begin
      rx_done_q  <= rx_done;
      started_q  <= 1'b1;
      wr         <= emit;
      frame_done <= emit && (addr_q == AddrLast);
      resync     <= expire;

      if (emit) begin
        wr_addr <= phys_addr;
        wr_data <= pix;
        addr_q  <= (addr_q == AddrLast) ? '0 : addr_q + 1'b1;
      end

      if (expire) begin
        tmo_q  <= '0;
        addr_q <= '0;
        if (accept) begin
          a_q     <= rx_data;
          phase_q <= StP1;
        end else begin
          phase_q <= StP0;
        end
      end else if (accept) begin
        tmo_q <= '0;
        unique case (phase_q)
          StP0: begin
            a_q     <= rx_data;
            phase_q <= StP1;
          end
          StP1: begin
            b_q     <= rx_data;
            phase_q <= StP2;
          end
          StP2:    phase_q <= StP0;
          default: phase_q <= StP0;
        endcase
      end else if (!idle && (tmo_q != TmoLast)) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_pixel_unpacker.sv
// Randomised bench for uart_pixel_unpacker with a byte-level reference model.
module tb_uart_pixel_unpacker;

  localparam int T = 300;
  localparam int F = 512;
`ifdef UART_PIXEL_UNPACKER_SERPENTINE_EN
  localparam int ExpA32 = 63;
  localparam int ExpA33 = 62;
  localparam int ExpA64 = 64;
  localparam int ExpA511 = 480;
`else
  localparam int ExpA32 = 32;
  localparam int ExpA33 = 33;
  localparam int ExpA64 = 64;
  localparam int ExpA511 = 511;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       wr;
  logic [9:0] wr_addr;
  logic [11:0] wr_data;
  logic       frame_done;
  logic       resync;
  logic [1:0] byte_phase;

  uart_pixel_unpacker #(
    .ADDR_W        (10),
    .FRAME_PIXELS  (F),
    .COLS_LOG2     (5),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .wr        (wr),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_done(frame_done),
    .resync    (resync),
    .byte_phase(byte_phase)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [11:0] data;
    logic        fd;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        wlog[$];
  int         rs_q[$];
  logic [7:0] mbuf[$];
  int         mpix = 0;
  int         last_acc = 0;
  int         checks = 0;
  int         errors = 0;
  int         res_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] phys(input int p);
    logic [9:0] a;
    a = p[9:0];
`ifdef UART_PIXEL_UNPACKER_SERPENTINE_EN
    if (a[5]) a[4:0] = ~a[4:0];
`endif
    return a;
  endfunction

  function automatic int log_addr(input int i);
    if (i < wlog.size()) return int'(wlog[i].addr);
    return -1;
  endfunction

  function automatic int log_data(input int i);
    if (i < wlog.size()) return int'(wlog[i].data);
    return -1;
  endfunction

  // Reference model: bytes grouped in threes, pixel counter modulo F, timeout after T idle cycles.
  task automatic model_emit(input logic [11:0] d, input int c);
    wr_t e;
    e.cyc  = c;
    e.addr = phys(mpix);
    e.data = d;
    e.fd   = (mpix == F - 1);
    exp_q.push_back(e);
    mpix = (mpix + 1) % F;
  endtask

  task automatic model_timeout(input int c);
    if ((mbuf.size() != 0 || mpix != 0) && c >= last_acc + T) begin
      rs_q.push_back(last_acc + T + 1);
      mbuf.delete();
      mpix = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int c);
    logic [7:0] b0;
    logic [7:0] b1;
    model_timeout(c);
    last_acc = c;
    mbuf.push_back(b);
    if (mbuf.size() == 2) begin
      b0 = mbuf[0];
      model_emit({b0, b[7:4]}, c + 1);
    end else if (mbuf.size() == 3) begin
      b1 = mbuf[1];
      model_emit({b1[3:0], b}, c + 1);
      mbuf.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    rx_data = b;
    rx_done = 1'b1;
    model_byte(b, cyc);
    repeat (hi) begin @(posedge clk); #1; end
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    repeat (lo) begin @(posedge clk); #1; end
  endtask

  task automatic send_rand(input logic [7:0] b);
    send_byte(b, int'($urandom_range(3, 1)), int'($urandom_range(2, 1)));
  endtask

  task automatic idle(input int n);
    model_timeout(cyc + n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_resync"}, resync, 0);
    chk({tag, "_byte_phase"}, byte_phase, 0);
  endtask

  task automatic compare_loop();
    wr_t e;
    wr_t o;
    int  r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wr) begin
          o.cyc  = cyc;
          o.addr = wr_addr;
          o.data = wr_data;
          o.fd   = frame_done;
          wlog.push_back(o);
          chk("wr_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_cycle", cyc, e.cyc);
            chk("wr_addr", int'(wr_addr), int'(e.addr));
            chk("wr_data", int'(wr_data), int'(e.data));
            chk("frame_done", int'(frame_done), int'(e.fd));
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          chk("wr_strobe", int'(wr), 1);
          e = exp_q.pop_front();
        end
        if (frame_done && !wr) chk("frame_done_with_wr", int'(wr), 1);
        if (resync) begin
          res_cnt++;
          chk("resync_expected", int'(rs_q.size() != 0), 1);
          if (rs_q.size() != 0) begin
            r = rs_q.pop_front();
            chk("resync_cycle", cyc, r);
          end
        end else if (rs_q.size() != 0 && rs_q[0] <= cyc) begin
          chk("resync_strobe", int'(resync), 1);
          r = rs_q.pop_front();
        end
      end
    end
  endtask

  initial begin
    int a;
    int n;
    int fdc;
    int fdi;
    fork
      compare_loop();
    join_none

    // Reset with rx_done already high: releasing reset must not accept a byte.
    rx_done = 1'b1;
    rx_data = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rx_done = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("held_high_phase", byte_phase, 0);
    chk("held_high_writes", wlog.size(), 0);

    // Packing order.
    wlog.delete();
    send_byte(8'hAB, 20, 2);
    send_byte(8'hCD, 20, 2);
    send_byte(8'hEF, 20, 2);
    chk("pack_count", wlog.size(), 2);
    chk("pack_addr0", log_addr(0), 0);
    chk("pack_data0", log_data(0), 'hABC);
    chk("pack_addr1", log_addr(1), 1);
    chk("pack_data1", log_data(1), 'hDEF);
    chk("pack_phase", byte_phase, 0);
    idle(T + 5);

    // Timeout drops a half pixel.
    wlog.delete();
    send_rand(8'h12);
    send_rand(8'h34);
    chk("tmo_addr0", log_addr(0), 0);
    chk("tmo_data0", log_data(0), 'h123);
    n = res_cnt;
    idle(T + 10);
    chk("tmo_resync_count", res_cnt - n, 1);
    chk("tmo_no_write", wlog.size(), 1);
    chk("tmo_phase", byte_phase, 0);
    send_rand(8'h11);
    send_rand(8'h22);
    send_rand(8'h33);
    chk("tmo_addr1", log_addr(1), 0);
    chk("tmo_data1", log_data(1), 'h112);
    chk("tmo_addr2", log_addr(2), 1);
    chk("tmo_data2", log_data(2), 'h233);
    idle(T + 5);

    // Byte edge exactly in the expiry cycle.
    wlog.delete();
    send_byte(8'h5A, 1, 1);
    a = last_acc;
    idle(a + T - cyc);
    rx_data = 8'hC3;
    rx_done = 1'b1;
    model_byte(8'hC3, cyc);
    @(negedge clk);
    @(negedge clk);
    chk("coll_resync", resync, 1);
    chk("coll_phase", byte_phase, 1);
    @(posedge clk); #1;
    rx_done = 1'b0;
    @(posedge clk); #1;
    send_rand(8'h6B);
    send_rand(8'h7C);
    chk("coll_data0", log_data(0), 'hC36);
    chk("coll_addr0", log_addr(0), 0);
    chk("coll_data1", log_data(1), 'hB7C);
    idle(T + 5);

    // Full frame and wrap.
    wlog.delete();
    for (int i = 0; i < 768; i++) send_rand(8'($urandom));
    chk("frame_writes", wlog.size(), F);
    fdc = 0;
    fdi = -1;
    foreach (wlog[i]) begin
      if (wlog[i].fd) begin
        fdc++;
        fdi = i;
      end
    end
    chk("frame_done_count", fdc, 1);
    chk("frame_done_index", fdi, F - 1);
    chk("frame_last_addr", log_addr(F - 1), ExpA511);
    chk("map_pix32", log_addr(32), ExpA32);
    chk("map_pix33", log_addr(33), ExpA33);
    chk("map_pix64", log_addr(64), ExpA64);
    for (int i = 0; i < 3; i++) send_rand(8'($urandom));
    chk("wrap_addr0", log_addr(F), 0);
    chk("wrap_addr1", log_addr(F + 1), 1);
    idle(T + 5);

    // Random stream with gaps straddling the timeout.
    for (int i = 0; i < 300; i++) begin
      send_rand(8'($urandom));
      if ($urandom_range(19, 0) == 0) idle(T - 8 + int'($urandom_range(8, 0)));
    end
    idle(T + 5);

    // Asynchronous reset mid-pixel.
    send_rand(8'hAB);
    send_rand(8'hCD);
    send_rand(8'hEF);
    send_rand(8'h99);
    chk("pre_rst_phase", byte_phase, 1);
    chk("pre_rst_data", wr_data, 'hDEF);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    mbuf.delete();
    exp_q.delete();
    rs_q.delete();
    mpix = 0;
    #20;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    wlog.delete();
    send_rand(8'h21);
    send_rand(8'h43);
    send_rand(8'h65);
    chk("post_rst_addr0", log_addr(0), 0);
    chk("post_rst_data0", log_data(0), 'h214);
    chk("post_rst_addr1", log_addr(1), 1);
    chk("post_rst_data1", log_data(1), 'h365);
    chk("post_rst_phase", byte_phase, 0);

    idle(T + 5);
    chk("drain_writes", exp_q.size(), 0);
    chk("drain_resync", rs_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_pixel_unpacker.md
Name: uart_pixel_unpacker

Overview:
- Sits between the UART receiver and the `matrix` frame-buffer write port, in the clk100 domain.
- Converts the received byte stream into 12-bit pixel writes: 3 bytes become 2 pixels.
- Adds a frame-aligned address counter, a frame-complete pulse, and an inter-byte timeout that resynchronises a stream that has broken mid-pixel or mid-frame.

Parameters:
- ADDR_W, 10, width of wr_addr.
- FRAME_PIXELS, 512, pixels per frame (16x32). Must be even and no greater than 2^ADDR_W.
- COLS_LOG2, 5, log2 of pixels per row. Used only by the optional feature.
- TIMEOUT_CYCLES, 1000000, idle clk cycles before a partial pixel/frame is discarded (10 ms at 100 MHz). Must be at least 2.

Ports:
- clk  in  1  write-side clock (clk100).
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid while rx_done is high.
- rx_done  in  1  UART completion level; may stay high for many clk cycles per byte.
- wr  out  1  one-cycle frame-buffer write strobe.
- wr_addr  out  ADDR_W  pixel address.
- wr_data  out  12  pixel, {R[3:0],G[3:0],B[3:0]}.
- frame_done  out  1  one-cycle pulse, coincident with the write of pixel FRAME_PIXELS-1.
- resync  out  1  one-cycle pulse when the timeout discards partial state.
- byte_phase  out  2  current unpack phase (0,1,2), for debug LEDs.

Behaviour:
- Reset (asynchronous, rst_n low): wr=0, wr_addr=0, wr_data=0, frame_done=0, resync=0, byte_phase=0, held-byte registers=0, timeout counter=0, rx_done history=0.
- Byte acceptance:
  - rx_done is registered into rx_done_q.
  - A byte is accepted in the cycle where rx_done=1 and rx_done_q=0 (rising edge). Exactly one byte per rising edge, regardless of how long rx_done stays high.
  - rx_data is captured in the accept cycle.
- Phase state machine (byte_phase):
  - P0: store byte as A, go to P1. No write.
  - P1: store byte as B. Emit pixel {A, B[7:4]}. Go to P2.
  - P2: emit pixel {B[3:0], C}, where C is the current byte. Go to P0.
- Write timing:
  - wr rises on the clk edge following the accept cycle, i.e. 1 cycle latency from the accept cycle.
  - wr_addr and wr_data are valid while wr=1 and hold until the next write.
- Address:
  - The first pixel after reset, resync or frame completion is written to address 0.
  - The logical address increments by 1 after each write.
  - The write at address FRAME_PIXELS-1 asserts frame_done in the same cycle as wr. The next write goes to 0. byte_phase is 0 at that point by construction, since FRAME_PIXELS is even.
- Timeout:
  - The counter clears on every accepted byte.
  - Otherwise it increments, saturating, while the block is not idle. Idle means byte_phase=0 and logical address=0.
  - When the counter reaches TIMEOUT_CYCLES-1: byte_phase goes to 0, logical address to 0, resync pulses for one cycle, counter clears. A half-assembled pixel is dropped and never written.
- Simultaneous timeout expiry and byte accept: the timeout wins first. The byte is then accepted as the P0 byte of a fresh stream. resync=1 in that cycle.
- An rx_done level already high at reset release is not an edge. No byte is accepted until rx_done falls and rises again.
- Throughput: one byte per 2 clk minimum. Bytes arriving faster are outside the operating envelope and undefined.

Optional Feature:
- Macro: UART_PIXEL_UNPACKER_SERPENTINE_EN.
- Defined: for physical rows with bit COLS_LOG2 of the logical address equal to 1 (odd rows), wr_addr = {addr[ADDR_W-1:COLS_LOG2], ~addr[COLS_LOG2-1:0]}. The column order is reversed for serpentine-wired panels. Even rows pass through unchanged. frame_done and the wrap still use the logical address.
- Not defined: wr_addr equals the logical address. No remap logic is present.

Test Plan:
- Ordering/packing: after reset, send bytes 0xAB, 0xCD, 0xEF with rx_done high 20 cycles each. Expect exactly 2 writes: addr 0 data 0xABC, then addr 1 data 0xDEF. byte_phase ends at 0.
- Frame wrap: stream 768 bytes (512 pixels). Expect 512 writes with addr 0..511, frame_done only with addr 511. The next 3 bytes write addr 0 and addr 1.
- Timeout: send 0x12, 0x34 (pixel 0x123 written at addr 0), then idle for TIMEOUT_CYCLES. Expect a resync pulse and no write. Next bytes 0x11, 0x22, 0x33 write 0x112 at addr 0 and 0x233 at addr 1.
- Rising-edge handling and async reset: rx_done held high across reset release gives no accept. Then assert rst_n low mid-pixel after one byte; outputs clear immediately without waiting for a clock. The following stream restarts at addr 0, phase 0.
- Collision: a byte edge in the exact timeout-expiry cycle gives resync=1 and byte_phase=1, with the held byte equal to that byte.
- Serpentine (macro defined): logical pixel 32 goes to wr_addr 63, logical 33 to 62, logical 64 to 64. Macro undefined: identity mapping.
